fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and decoder.
- Owns the PC register and issues word requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions with their PC in a small FIFO.
- Presents instructions to decode over a valid/ready handshake, and accepts a redirect (branch/JAL target computed from PC + imm_out) that flushes all in-flight and buffered work.

---
 rtl/fetch_if.sv | 21 ++
 rtl/fetch_unit.sv | 63 ++++++
 tb/tb_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, decode handshake and redirect signals of the fetch stage
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, misalign_err,
    input  imem_rdata, instr_ready, redirect_valid, redirect_target
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, misalign_err,
    output imem_rdata, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, 1-cycle imem requests and a fall-through instruction FIFO
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  fetch_if.master f
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc, req_pc_q;
  logic          inflight, misalign_q;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem  [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];
  logic          empty, issue, bypass, push, pop;
  assign empty  = count == '0;
  assign issue  = !rst && !f.redirect_valid && (count + CW'(inflight) < CW'(FIFO_DEPTH));
  // a returning word with nothing buffered ahead of it goes straight to decode
  assign bypass = empty && inflight && f.instr_ready;
  assign push   = inflight && !f.redirect_valid && !bypass;
  assign pop    = !empty && f.instr_ready && !f.redirect_valid;
  assign f.imem_req     = issue;
  assign f.imem_addr    = issue ? pc : 32'h0;
  assign f.instr_valid  = !empty || inflight;
  assign f.instruction  = !empty ? ins_mem[rd_ptr] : inflight ? f.imem_rdata : 32'h0;
  assign f.instr_pc     = !empty ? pc_mem[rd_ptr] : inflight ? req_pc_q : 32'h0;
  assign f.misalign_err = misalign_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight   <= 1'b0;
      misalign_q <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      inflight   <= issue;
      misalign_q <= f.redirect_valid && |f.redirect_target[1:0];
      if (issue) begin
        pc       <= pc + 32'd4;
        req_pc_q <= pc;
      end
      if (f.redirect_valid) begin
        pc     <= {f.redirect_target[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]  <= req_pc_q;
          ins_mem[wr_ptr] <= f.imem_rdata;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model compared every cycle, directed and random stimulus
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if f();
  fetch_if w();
  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .f(f));
  fetch_unit #(.RESET_PC(32'hFFFFFFF8), .FIFO_DEPTH(DEPTH)) dut2 (.clk(clk), .rst(rst), .f(w));
  int tests = 0;
  int fails = 0;
  bit on = 1'b0;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A5AC3C3;
  endfunction
  always @(posedge clk) begin
    f.imem_rdata <= f.imem_req ? mem_word(f.imem_addr) : $urandom;
    w.imem_rdata <= w.imem_req ? mem_word(w.imem_addr) : 32'h0;
  end
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, exp);
    end
  endtask
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        fq[$];
  bit          pend = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  logic [31:0] m_pc = 32'h0;
  bit          m_mis = 1'b0;
  always @(negedge clk) begin
    bit   ereq, ev;
    ent_t hd, in_e;
    in_e = '{pc: pend_pc, ins: f.imem_rdata};
    ereq = !rst && !f.redirect_valid && (fq.size() + int'(pend) < DEPTH);
    ev   = fq.size() > 0 || pend;
    hd   = fq.size() > 0 ? fq[0] : (pend ? in_e : '0);
    if (on) begin
      chk("imem_req", 32'(f.imem_req), 32'(ereq));
      chk("imem_addr", f.imem_addr, ereq ? m_pc : 32'h0);
      chk("instr_valid", 32'(f.instr_valid), 32'(ev));
      chk("instruction", f.instruction, hd.ins);
      chk("instr_pc", f.instr_pc, hd.pc);
      chk("misalign_err", 32'(f.misalign_err), 32'(m_mis));
    end
    if (rst) begin
      m_pc = 32'h0; fq.delete(); pend = 1'b0; m_mis = 1'b0;
    end else begin
      m_mis = f.redirect_valid && f.redirect_target[1:0] != 2'b00;
      if (f.redirect_valid) begin
        fq.delete(); pend = 1'b0; m_pc = f.redirect_target & ~32'h3;
      end else begin
        if (pend) fq.push_back(in_e);
        if (ev && f.instr_ready) void'(fq.pop_front());
        pend = ereq;
        if (ereq) begin
          pend_pc = m_pc;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end
  task automatic step(bit r, bit rv, logic [31:0] t, bit rd);
    @(posedge clk);
    #1;
    rst = r;
    f.redirect_valid  = rv;
    f.redirect_target = t;
    f.instr_ready     = rd;
    @(negedge clk);
  endtask
  initial begin
    f.instr_ready = 1'b0; f.redirect_valid = 1'b0; f.redirect_target = 32'h0;
    w.instr_ready = 1'b1; w.redirect_valid = 1'b0; w.redirect_target = 32'h0;
    step(1, 0, 0, 0);
    on = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("c1_addr", f.imem_addr, 32'h0);
    chk("c1_valid", 32'(f.instr_valid), 32'h0);
    chk("wrap_addr0", w.imem_addr, 32'hFFFFFFF8);
    step(0, 0, 0, 0);
    chk("c2_pc", f.instr_pc, 32'h0);
    chk("c2_valid", 32'(f.instr_valid), 32'h1);
    chk("wrap_addr1", w.imem_addr, 32'hFFFFFFFC);
    chk("wrap_pc0", w.instr_pc, 32'hFFFFFFF8);
    step(0, 0, 0, 0);
    chk("wrap_addr2", w.imem_addr, 32'h0);
    chk("wrap_pc1", w.instr_pc, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    chk("full_req", 32'(f.imem_req), 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("drain_pc0", f.instr_pc, 32'h0);
    step(0, 0, 0, 1);
    chk("refill_addr", f.imem_addr, 32'h8);
    chk("drain_pc4", f.instr_pc, 32'h4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    step(0, 0, 0, 1);
    chk("redir_addr", f.imem_addr, 32'h100);
    chk("redir_flush", 32'(f.instr_valid), 32'h0);
    step(0, 0, 0, 1);
    chk("redir_pc", f.instr_pc, 32'h100);
    step(0, 1, 32'h102, 1);
    step(0, 0, 0, 1);
    chk("mis_pulse", 32'(f.misalign_err), 32'h1);
    chk("mis_addr", f.imem_addr, 32'h100);
    step(0, 0, 0, 1);
    chk("mis_clear", 32'(f.misalign_err), 32'h0);
    chk("mis_pc", f.instr_pc, 32'h100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", 32'(f.instr_valid), 32'h0);
    chk("rst_pc", f.instr_pc, 32'h0);
    step(0, 0, 0, 1);
    chk("rst_first_pc", f.instr_pc, 32'h0);
    chk("rst_first_valid", 32'(f.instr_valid), 32'h1);
    for (int i = 0; i < 3000; i++) begin
      bit r, rv;
      logic [31:0] t;
      r  = $urandom_range(0, 99) == 0;
      rv = !r && $urandom_range(0, 19) == 0;
      t  = $urandom_range(0, 3) == 0 ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, rv, t, $urandom_range(0, 9) < 7);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
